// File: rtl/he_hssi_tm_checker_if.sv
// RX AXI-Stream bundle between the HSSI receive path and the traffic monitor.
interface he_hssi_tm_checker_if #(
  parameter int DATA_W = 64
);
  logic                  rx_tvalid;
  logic                  rx_tready;
  logic [DATA_W-1:0]     rx_tdata;
  logic [DATA_W/8-1:0]   rx_tkeep;
  logic                  rx_tlast;
  logic                  rx_tuser_err;

  modport master (
    output rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, rx_tuser_err,
    input  rx_tready
  );

  modport slave (
    input  rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, rx_tuser_err,
    output rx_tready
  );
endinterface

// File: rtl/he_hssi_tm_checker.sv
// HE-HSSI loopback traffic monitor: checks length, data pattern and error
// flag of each received packet and keeps good/bad/byte counters.
module he_hssi_tm_checker #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [31:0]       cfg_num_pkt,
  input  logic [15:0]       cfg_pkt_len,
  input  logic              cfg_data_pattern,
  he_hssi_tm_checker_if.slave rx,
  output logic [CNT_W-1:0]  pkt_good_cnt,
  output logic [CNT_W-1:0]  pkt_bad_cnt,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              busy,
  output logic              done
);

  localparam int BYTES = DATA_W / 8;
  localparam int CW    = $clog2(BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_nx;

  logic              ready_r;
  logic              in_pkt_r, in_pkt_nx;
  logic              discard_r, discard_nx;
  logic [15:0]       off_r;
  logic              err_r;
  logic              over_r;
  logic              pat_r;
  logic [15:0]       len_r;
  logic [31:0]       num_r;
  logic [CNT_W-1:0]  good_r, bad_r, bytes_r;
  logic [CNT_W-1:0]  good_nx, bad_nx, bytes_nx;

  logic              take, sop, count_beat, pkt_end;
  logic [15:0]       eff_off, eff_len, off_nx;
  logic              eff_err, eff_over, eff_pat, over_nx;
  logic [31:0]       eff_num;
  logic [16:0]       beat_bytes, sum17;
  logic              beat_err, len_bad, pkt_bad, reach;
  logic [CNT_W:0]    total_pkts;

  // Number of enabled bytes in a beat.
  function automatic logic [CW-1:0] popcount(input logic [BYTES-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < BYTES; i++) begin
      c = c + CW'(k[i]);
    end
    return c;
  endfunction

  // Non-zero keep whose ones are packed from bit 0 upward.
  function automatic logic keep_contig(input logic [BYTES-1:0] k);
    logic [BYTES-1:0] one;
    one = BYTES'(1);
    return (k != '0) && ((k & (k + one)) == '0);
  endfunction

  // Any enabled byte differing from the expected pattern at its offset.
  function automatic logic data_mismatch(input logic [DATA_W-1:0] d,
                                         input logic [BYTES-1:0]  k,
                                         input logic [15:0]       off,
                                         input logic              pat);
    logic       bad;
    logic [7:0] exp_b;
    bad = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      exp_b = pat ? 8'(off + 16'(i)) : 8'h5A;
      if (k[i] && (d[i*8 +: 8] != exp_b)) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  // Saturating add of a small value into a counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [16:0]      b);
    logic [CNT_W+17:0] s;
    s = {{18{1'b0}}, a} + {{(CNT_W+1){1'b0}}, b};
    if (s > {{18{1'b0}}, {CNT_W{1'b1}}}) begin
      return {CNT_W{1'b1}};
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  assign take       = rx.rx_tvalid & ready_r;
  assign sop        = ~in_pkt_r;
  assign count_beat = take & (state_r == RUN) & ~discard_r & ~cfg_start;
  assign pkt_end    = count_beat & rx.rx_tlast;

  // Per-beat checks against the packet context (config latched at SOP).
  always_comb begin
    eff_off    = sop ? 16'h0000 : off_r;
    eff_err    = sop ? 1'b0 : err_r;
    eff_over   = sop ? 1'b0 : over_r;
    eff_pat    = sop ? cfg_data_pattern : pat_r;
    eff_len    = sop ? cfg_pkt_len : len_r;
    eff_num    = sop ? cfg_num_pkt : num_r;
    beat_bytes = 17'(popcount(rx.rx_tkeep));
    sum17      = {1'b0, eff_off} + beat_bytes;
    off_nx     = sum17[16] ? 16'hFFFF : sum17[15:0];
    over_nx    = eff_over | sum17[16];
    beat_err   = rx.rx_tuser_err
               | data_mismatch(rx.rx_tdata, rx.rx_tkeep, eff_off, eff_pat)
               | (~rx.rx_tlast & (rx.rx_tkeep != '1))
               | (rx.rx_tlast & ~keep_contig(rx.rx_tkeep));
    len_bad    = over_nx | (off_nx != eff_len);
    pkt_bad    = eff_err | beat_err | len_bad;
  end

  // Counter next values: start clears, otherwise a finished packet updates.
  always_comb begin
    good_nx  = good_r;
    bad_nx   = bad_r;
    bytes_nx = bytes_r;
    if (cfg_start) begin
      good_nx  = '0;
      bad_nx   = '0;
      bytes_nx = '0;
    end else if (pkt_end) begin
      if (pkt_bad) begin
        bad_nx = sat_add(bad_r, 17'd1);
      end else begin
        good_nx = sat_add(good_r, 17'd1);
      end
      bytes_nx = sat_add(bytes_r, {1'b0, off_nx});
    end else begin
      good_nx  = good_r;
      bad_nx   = bad_r;
      bytes_nx = bytes_r;
    end
    total_pkts = {1'b0, good_nx} + {1'b0, bad_nx};
    reach      = (eff_num != 32'd0) &&
                 ({32'd0, total_pkts} == {{(CNT_W+1){1'b0}}, eff_num});
  end

  // Packet boundary tracking and discard of a packet interrupted by start.
  always_comb begin
    in_pkt_nx = take ? ~rx.rx_tlast : in_pkt_r;
    if (cfg_start) begin
      discard_nx = in_pkt_nx;
    end else if (take && rx.rx_tlast) begin
      discard_nx = 1'b0;
    end else begin
      discard_nx = discard_r;
    end
  end

  // Next-state logic of the run/done controller.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (cfg_start) state_nx = RUN;
        else           state_nx = IDLE;
      end
      RUN: begin
        if (cfg_start)            state_nx = RUN;
        else if (pkt_end && reach) state_nx = DONE;
        else                      state_nx = RUN;
      end
      DONE: begin
        if (cfg_start) state_nx = RUN;
        else           state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Controller state, ready and packet-boundary registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ready_r   <= 1'b0;
      in_pkt_r  <= 1'b0;
      discard_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      ready_r   <= 1'b1;
      in_pkt_r  <= in_pkt_nx;
      discard_r <= discard_nx;
    end
  end

  // Packet context and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_r   <= 16'h0000;
      err_r   <= 1'b0;
      over_r  <= 1'b0;
      pat_r   <= 1'b0;
      len_r   <= 16'h0000;
      num_r   <= 32'd0;
      good_r  <= '0;
      bad_r   <= '0;
      bytes_r <= '0;
    end else begin
      if (count_beat) begin
        off_r  <= off_nx;
        err_r  <= eff_err | beat_err;
        over_r <= over_nx;
        pat_r  <= eff_pat;
        len_r  <= eff_len;
        num_r  <= eff_num;
      end
      good_r  <= good_nx;
      bad_r   <= bad_nx;
      bytes_r <= bytes_nx;
    end
  end

  assign rx.rx_tready  = ready_r;
  assign pkt_good_cnt  = good_r;
  assign pkt_bad_cnt   = bad_r;
  assign byte_cnt      = bytes_r;
  assign busy          = (state_r == RUN);
  assign done          = (state_r == DONE);

endmodule

// File: tb/tb_he_hssi_tm_checker.sv
// Directed, table-driven bench for the HE-HSSI traffic monitor.
module tb_he_hssi_tm_checker;

  logic        clk;
  logic        rst;
  logic        cfg_start, cfg_start2;
  logic [31:0] cfg_num_pkt;
  logic [15:0] cfg_pkt_len;
  logic        cfg_data_pattern;

  logic [31:0] good, bad, bytes;
  logic        busy, done;
  logic [1:0]  good2, bad2, bytes2;
  logic        busy2, done2;

  int n_chk  = 0;
  int n_fail = 0;

  he_hssi_tm_checker_if #(.DATA_W(64)) rx1 ();
  he_hssi_tm_checker_if #(.DATA_W(64)) rx2 ();

  assign rx2.rx_tvalid    = rx1.rx_tvalid;
  assign rx2.rx_tdata     = rx1.rx_tdata;
  assign rx2.rx_tkeep     = rx1.rx_tkeep;
  assign rx2.rx_tlast     = rx1.rx_tlast;
  assign rx2.rx_tuser_err = rx1.rx_tuser_err;

  he_hssi_tm_checker #(.DATA_W(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_num_pkt(cfg_num_pkt),
    .cfg_pkt_len(cfg_pkt_len), .cfg_data_pattern(cfg_data_pattern),
    .rx(rx1),
    .pkt_good_cnt(good), .pkt_bad_cnt(bad), .byte_cnt(bytes),
    .busy(busy), .done(done)
  );

  // Narrow-counter instance used to exercise saturation.
  he_hssi_tm_checker #(.DATA_W(64), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start2), .cfg_num_pkt(cfg_num_pkt),
    .cfg_pkt_len(cfg_pkt_len), .cfg_data_pattern(cfg_data_pattern),
    .rx(rx2),
    .pkt_good_cnt(good2), .pkt_bad_cnt(bad2), .byte_cnt(bytes2),
    .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         nbytes;
    bit         dpat;
    bit         cpat;
    int         len;
    int         cor;
    int         errb;
    logic [7:0] lk;
    bit         is_bad;
    int         exp_bytes;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                      input logic e, input logic st);
    rx1.rx_tvalid    = 1'b1;
    rx1.rx_tdata     = d;
    rx1.rx_tkeep     = k;
    rx1.rx_tlast     = l;
    rx1.rx_tuser_err = e;
    cfg_start        = st;
    @(posedge clk); #1;
    rx1.rx_tvalid    = 1'b0;
    rx1.rx_tlast     = 1'b0;
    rx1.rx_tuser_err = 1'b0;
    cfg_start        = 1'b0;
  endtask

  // One packet: dpat selects 5A or incrementing data; cor = byte index forced
  // to 00; errb = beat with tuser_err; lk != 0 overrides last keep;
  // start_beat = beat carrying a cfg_start pulse (-1 = none).
  task automatic send_pkt(input int nbytes, input bit dpat, input int cor,
                          input int errb, input logic [7:0] lk, input int start_beat);
    int          nb, rem, idx;
    logic [63:0] d;
    logic [7:0]  k;
    logic [7:0]  bv;
    nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 8; i++) begin
        idx = b * 8 + i;
        bv  = dpat ? 8'(idx) : 8'h5A;
        if (idx == cor) bv = 8'h00;
        d[i*8 +: 8] = bv;
      end
      k = 8'hFF;
      if (b == nb - 1) begin
        rem = nbytes - b * 8;
        if (rem < 8) k = 8'hFF >> (8 - rem);
        if (lk != 8'h00) k = lk;
      end
      beat(d, k, (b == nb - 1), (b == errb), (b == start_beat));
    end
  endtask

  initial begin
    int eg, eb, ey;
    rst = 1'b1;
    cfg_start = 1'b0; cfg_start2 = 1'b0;
    cfg_num_pkt = 32'd0; cfg_pkt_len = 16'd64; cfg_data_pattern = 1'b1;
    rx1.rx_tvalid = 1'b0; rx1.rx_tdata = 64'd0; rx1.rx_tkeep = 8'h00;
    rx1.rx_tlast = 1'b0; rx1.rx_tuser_err = 1'b0;

    //            nbytes dpat cpat len  cor errb lk     bad bytes
    tbl[0] = '{64, 1'b1, 1'b1, 64, -1, -1, 8'h00, 1'b0, 64};
    tbl[1] = '{61, 1'b0, 1'b0, 61, -1, -1, 8'h00, 1'b0, 61};
    tbl[2] = '{61, 1'b0, 1'b0, 61, 17, -1, 8'h00, 1'b1, 61};
    tbl[3] = '{61, 1'b0, 1'b0, 61, -1,  2, 8'h00, 1'b1, 61};
    tbl[4] = '{56, 1'b1, 1'b1, 64, -1, -1, 8'h00, 1'b1, 56};
    tbl[5] = '{72, 1'b1, 1'b1, 64, -1, -1, 8'h00, 1'b1, 72};
    tbl[6] = '{64, 1'b1, 1'b1, 64, -1, -1, 8'hF0, 1'b1, 60};
    tbl[7] = '{16, 1'b0, 1'b1, 16, -1, -1, 8'h00, 1'b1, 16};
    tbl[8] = '{ 1, 1'b1, 1'b1,  1, -1, -1, 8'h00, 1'b0,  1};

    // Reset state and ready release.
    #12;
    chk("reset_ready", 32'(rx1.rx_tready), 32'd0);
    chk("reset_good", good, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(rx1.rx_tready), 32'd1);

    // Good run: 4 x 64-byte incrementing packets.
    cfg_num_pkt = 32'd4; cfg_pkt_len = 16'd64; cfg_data_pattern = 1'b1;
    pulse_start();
    chk("run_busy", 32'(busy), 32'd1);
    for (int p = 0; p < 4; p++) begin
      send_pkt(64, 1'b1, -1, -1, 8'h00, -1);
      if (p == 2) chk("run_done_early", 32'(done), 32'd0);
    end
    chk("run_good", good, 32'd4);
    chk("run_bad", bad, 32'd0);
    chk("run_bytes", bytes, 32'd256);
    chk("run_done", 32'(done), 32'd1);
    chk("run_busy_end", 32'(busy), 32'd0);
    send_pkt(64, 1'b1, -1, -1, 8'h00, -1);
    chk("done_drop_good", good, 32'd4);
    chk("done_drop_bytes", bytes, 32'd256);

    // Table of single packets in continuous mode.
    cfg_num_pkt = 32'd0;
    pulse_start();
    chk("tbl_clear", bytes, 32'd0);
    eg = 0; eb = 0; ey = 0;
    for (int v = 0; v < 9; v++) begin
      cfg_pkt_len      = 16'(tbl[v].len);
      cfg_data_pattern = tbl[v].cpat;
      send_pkt(tbl[v].nbytes, tbl[v].dpat, tbl[v].cor, tbl[v].errb, tbl[v].lk, -1);
      if (tbl[v].is_bad) eb++; else eg++;
      ey += tbl[v].exp_bytes;
      chk($sformatf("tbl%0d_good", v), good, 32'(eg));
      chk($sformatf("tbl%0d_bad", v), bad, 32'(eb));
      chk($sformatf("tbl%0d_bytes", v), bytes, 32'(ey));
    end
    chk("tbl_busy", 32'(busy), 32'd1);

    // Mid-packet restart on beat 3, then 2 good packets.
    cfg_num_pkt = 32'd2; cfg_pkt_len = 16'd64; cfg_data_pattern = 1'b1;
    send_pkt(64, 1'b1, -1, -1, 8'h00, 2);
    chk("mid_good", good, 32'd0);
    chk("mid_bad", bad, 32'd0);
    chk("mid_bytes", bytes, 32'd0);
    send_pkt(64, 1'b1, -1, -1, 8'h00, -1);
    send_pkt(64, 1'b1, -1, -1, 8'h00, -1);
    chk("mid_good2", good, 32'd2);
    chk("mid_bytes2", bytes, 32'd128);
    chk("mid_done", 32'(done), 32'd1);

    // Start coincident with tlast: packet not counted, next beat is SOP.
    cfg_num_pkt = 32'd0;
    send_pkt(64, 1'b1, -1, -1, 8'h00, 7);
    chk("last_start_good", good, 32'd0);
    chk("last_start_busy", 32'(busy), 32'd1);
    send_pkt(64, 1'b1, -1, -1, 8'h00, -1);
    chk("last_start_good2", good, 32'd1);
    chk("last_start_bytes", bytes, 32'd64);

    // Saturation on the 2-bit-counter instance, continuous mode.
    cfg_pkt_len = 16'd8; cfg_data_pattern = 1'b1;
    cfg_start2 = 1'b1;
    @(posedge clk); #1;
    cfg_start2 = 1'b0;
    for (int p = 0; p < 5; p++) begin
      send_pkt(8, 1'b1, -1, -1, 8'h00, -1);
      if (p == 1) begin
        chk("sat_good_mid", 32'(good2), 32'd2);
        chk("sat_bytes_mid", 32'(bytes2), 32'd3);
      end
    end
    chk("sat_good", 32'(good2), 32'd3);
    chk("sat_bad", 32'(bad2), 32'd0);
    chk("sat_bytes", 32'(bytes2), 32'd3);
    chk("sat_done", 32'(done2), 32'd0);
    chk("sat_busy", 32'(busy2), 32'd1);
    chk("sat_main_good", good, 32'd6);

    // Asynchronous reset in the middle of a packet.
    beat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_good", good, 32'd0);
    chk("mrst_bytes", bytes, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(rx1.rx_tready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_ready_rel", 32'(rx1.rx_tready), 32'd1);
    chk("mrst_idle", 32'(busy | done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/he_hssi_tm_checker.md
Name: he_hssi_tm_checker

Overview:
- Receive-side traffic monitor for the HE-HSSI loopback test. Sits downstream of the HSSI RX AXI-S path and consumes looped-back packets from the traffic generator.
- Checks each packet's length, data pattern and error flag, and counts good and bad packets.
- Drives the TM_PKT_GOOD / TM_PKT_BAD CSR read values and a done status back to the CSR block.

Parameters:
- DATA_W, 64, RX tdata width in bits; multiple of 8; bytes = DATA_W/8.
- CNT_W, 32, width of packet and byte counters.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; clears counters and arms the monitor (from TG_START_XFR write).
- cfg_num_pkt  in  32  packets to expect; 0 = run continuously.
- cfg_pkt_len  in  16  expected packet length in bytes, 1..65535.
- cfg_data_pattern  in  1  0 = fixed byte 8'h5A; 1 = incrementing byte index mod 256.
- rx_tvalid  in  1  AXI-S valid.
- rx_tready  out  1  AXI-S ready.
- rx_tdata  in  DATA_W  byte 0 of the beat is in [7:0].
- rx_tkeep  in  DATA_W/8  byte enables.
- rx_tlast  in  1  end of packet.
- rx_tuser_err  in  1  MAC error for this beat.
- pkt_good_cnt  out  CNT_W  good packets.
- pkt_bad_cnt  out  CNT_W  bad packets.
- byte_cnt  out  CNT_W  bytes accepted in counted packets.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (async assert, sync deassert by the caller):
  - all counters = 0, state = IDLE, busy = 0, done = 0, rx_tready = 0.
  - rx_tready = 1 from the first clock edge after rst deasserts; it is never deasserted afterwards (the monitor never backpressures).
- Handshake: a beat is taken when rx_tvalid & rx_tready. Beats taken in IDLE or DONE are dropped and not counted.
- States:
  - IDLE -> RUN on cfg_start.
  - RUN -> DONE when cfg_num_pkt != 0 and (good + bad) reaches cfg_num_pkt.
  - DONE -> RUN on cfg_start.
  - cfg_start in RUN restarts: counters clear, state stays RUN.
- cfg_start clears good, bad and byte counters on the next edge.
- Packet tracking:
  - Byte offset register (16 bits) resets to 0 at SOP.
  - Expected byte at offset k: pattern 0 -> 8'h5A; pattern 1 -> k[7:0].
  - Offset saturates at 16'hFFFF.
- A packet is bad if any of the following holds:
  - any beat has rx_tuser_err = 1;
  - any enabled byte mismatches its expected value;
  - a non-last beat has tkeep != all ones;
  - the last beat's tkeep is not contiguous from bit 0, or is 0;
  - total enabled bytes != cfg_pkt_len.
- Otherwise the packet is good.
- Update timing:
  - On the tlast beat, the sticky error is evaluated together with that beat's checks.
  - Exactly one of good or bad increments on the next edge.
  - byte_cnt adds the packet's byte total on the same edge, for good and bad packets alike.
  - done rises on the same edge as the final count update.
- Mid-packet start:
  - If cfg_start arrives while a packet is in flight (SOP taken, tlast not yet taken), the remainder of that packet is discarded up to and including its tlast and is not counted.
  - cfg_start coincident with a tlast beat: start wins, that packet is not counted, and the next beat is SOP.
- Counters saturate at all ones and do not wrap.
- cfg_* inputs are sampled at SOP; changes mid-packet take effect from the next packet.
- Beat with tvalid = 1 and tkeep = 0 on a non-last beat: packet marked bad, offset not advanced.

Test Plan:
- Reset: rst high mid-stream -> all outputs 0 and state IDLE immediately; rx_tready = 1 one cycle after release.
- Good run: pattern = 1, len = 64, num_pkt = 4, DATA_W = 64, 4 × 8-beat packets with incrementing bytes -> good = 4, bad = 0, byte_cnt = 256, done = 1 on the edge after the 4th tlast, busy = 0.
- Error mix: len = 61, pattern = 0, 3 packets:
  - packet 1 correct (last tkeep = 8'h1F);
  - packet 2 with byte 17 = 8'h00;
  - packet 3 with tuser_err on beat 2;
  - expected: good = 1, bad = 2, byte_cnt = 183.
- Length faults: len = 64; send 56-byte and 72-byte packets, plus one with last tkeep = 8'hF0 -> bad = 3, good = 0.
- Mid-packet restart: pulse cfg_start on beat 3 of an 8-beat packet, then send 2 good packets with num_pkt = 2 -> good = 2, the partial packet is not counted, done = 1.
- Continuous/saturation: num_pkt = 0 with counters forced near 32'hFFFF_FFFE, send 3 good packets -> good = 32'hFFFF_FFFF, done stays 0, busy stays 1.
